// File: rtl/vga_rx_monitor.sv
// VGA timing recovery monitor: locks onto an incoming HS/VS/RGB stream, recovers
// active-pixel coordinates and captures one sample colour from each screen quadrant.
module vga_rx_monitor #(
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned H_ACT_OFS = 144,
  parameter int unsigned H_ACT     = 640,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned V_ACT_OFS = 35,
  parameter int unsigned V_ACT     = 480
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic [3:0]  i_r,
  input  logic [3:0]  i_g,
  input  logic [3:0]  i_b,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_de,
  output logic [11:0] o_rgb,
  output logic        o_locked,
  output logic        o_frame_start,
  output logic [11:0] o_color_a,
  output logic [11:0] o_color_b,
  output logic [11:0] o_color_c,
  output logic [11:0] o_color_d,
  output logic        o_colors_valid
);

  // Quadrant sample points sit at the centre of each quadrant of the active area.
  localparam int unsigned QX0 = H_ACT / 4;
  localparam int unsigned QX1 = 3 * H_ACT / 4;
  localparam int unsigned QY0 = V_ACT / 4;
  localparam int unsigned QY1 = 3 * V_ACT / 4;

  localparam logic [10:0] H_LO    = 11'(H_ACT_OFS);
  localparam logic [10:0] H_HI    = 11'(H_ACT_OFS + H_ACT);
  localparam logic [10:0] V_LO    = 11'(V_ACT_OFS);
  localparam logic [10:0] V_HI    = 11'(V_ACT_OFS + V_ACT);
  localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN   = 11'(V_TOTAL);
  localparam logic [9:0]  H_OFS10 = 10'(H_ACT_OFS);
  localparam logic [8:0]  V_OFS9  = 9'(V_ACT_OFS);
  localparam logic [9:0]  CAP_H0  = 10'(H_ACT_OFS + QX0);
  localparam logic [9:0]  CAP_H1  = 10'(H_ACT_OFS + QX1);
  localparam logic [9:0]  CAP_V0  = 10'(V_ACT_OFS + QY0);
  localparam logic [9:0]  CAP_V1  = 10'(V_ACT_OFS + QY1);
  localparam logic [9:0]  CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_t;

  state_t      state;
  logic        hs_prev, vs_prev;
  logic [11:0] rgb_smp;
  logic        stb_q;
  logic [9:0]  hcnt, vcnt;
  logic [3:0]  cap_flags, flags_d, cap_hit;
  logic        hs_fall, vs_fall, line_bad, frame_bad, sat, mismatch;
  logic        in_h, in_v, de_d;

  assign hs_fall   = i_pix_stb & hs_prev & ~i_hs;
  assign vs_fall   = i_pix_stb & vs_prev & ~i_vs;
  assign line_bad  = hs_fall && (({1'b0, hcnt} + 11'd1) != H_LEN);
  assign frame_bad = vs_fall && (({1'b0, vcnt} + 11'd1) != V_LEN);
  // A counter stuck at its ceiling means an expected sync edge never arrived.
  assign sat       = i_pix_stb && ((hcnt == CNT_MAX) || (vcnt == CNT_MAX));
  assign mismatch  = line_bad | frame_bad | sat;

  assign in_h = ({1'b0, hcnt} >= H_LO) && ({1'b0, hcnt} < H_HI);
  assign in_v = ({1'b0, vcnt} >= V_LO) && ({1'b0, vcnt} < V_HI);
  assign de_d = (state == StLocked) && in_h && in_v;

  assign cap_hit[0] = de_d && (hcnt == CAP_H0) && (vcnt == CAP_V0);
  assign cap_hit[1] = de_d && (hcnt == CAP_H1) && (vcnt == CAP_V0);
  assign cap_hit[2] = de_d && (hcnt == CAP_H0) && (vcnt == CAP_V1);
  assign cap_hit[3] = de_d && (hcnt == CAP_H1) && (vcnt == CAP_V1);

  always_comb begin
    flags_d = cap_flags;
    if (stb_q) flags_d = flags_d | cap_hit;
    if (vs_fall || ((state == StLocked) && mismatch)) flags_d = 4'b0000;
  end

  // Input sampling and line/frame counters, advanced on strobes only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      rgb_smp <= 12'h000;
      stb_q   <= 1'b0;
      hcnt    <= 10'd0;
      vcnt    <= 10'd0;
    end else begin
      stb_q <= i_pix_stb;
      if (i_pix_stb) begin
        hs_prev <= i_hs;
        vs_prev <= i_vs;
        rgb_smp <= {i_b, i_g, i_r};
        if (hs_fall) hcnt <= 10'd0;
        else if (hcnt != CNT_MAX) hcnt <= hcnt + 10'd1;
        if (vs_fall) vcnt <= 10'd0;
        else if (hs_fall && (vcnt != CNT_MAX)) vcnt <= vcnt + 10'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= StSearch;
      o_locked       <= 1'b0;
      o_frame_start  <= 1'b0;
      o_colors_valid <= 1'b0;
    end else begin
      o_frame_start  <= 1'b0;
      o_colors_valid <= 1'b0;
      if (i_pix_stb) begin
        unique case (state)
          StSearch: if (vs_fall) state <= StCheck;
          StCheck: begin
            if (mismatch) begin
              state <= StSearch;
            end else if (vs_fall) begin
              state    <= StLocked;
              o_locked <= 1'b1;
            end
          end
          StLocked: begin
            if (mismatch) begin
              state    <= StSearch;
              o_locked <= 1'b0;
            end else if (vs_fall) begin
              o_frame_start  <= 1'b1;
              o_colors_valid <= &cap_flags;
            end
          end
          default: begin
            state    <= StSearch;
            o_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pixel outputs follow the strobe by one CLK, once the counters reflect that sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_x       <= 10'd0;
      o_y       <= 9'd0;
      o_de      <= 1'b0;
      o_rgb     <= 12'h000;
      o_color_a <= 12'h000;
      o_color_b <= 12'h000;
      o_color_c <= 12'h000;
      o_color_d <= 12'h000;
      cap_flags <= 4'b0000;
    end else begin
      cap_flags <= flags_d;
      if (stb_q) begin
        o_rgb <= rgb_smp;
        o_de  <= de_d;
        if (de_d) begin
          o_x <= hcnt - H_OFS10;
          o_y <= vcnt[8:0] - V_OFS9;
        end
        if (cap_hit[0]) o_color_a <= rgb_smp;
        if (cap_hit[1]) o_color_b <= rgb_smp;
        if (cap_hit[2]) o_color_c <= rgb_smp;
        if (cap_hit[3]) o_color_d <= rgb_smp;
      end
    end
  end

endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_TOTAL 800 — pixel strobes per line.
- H_ACT_OFS 144 — strobes from HS falling edge to first active pixel.
- H_ACT 640 — active pixels per line.
- V_TOTAL 525 — lines per frame.
- V_ACT_OFS 35 — lines from VS falling edge to first active line.
- V_ACT 480 — active lines per frame.
REQ-002 Ports (name, direction, width, meaning), one per line:
- CLK in 1 — single system clock; all logic on its rising edge.
- RST in 1 — reset, asynchronous and active-high.
- i_pix_stb in 1 — pixel strobe, one CLK wide; all sampling is qualified by it.
- i_hs in 1 — horizontal sync, active low.
- i_vs in 1 — vertical sync, active low.
- i_r in 4 — red.
- i_g in 4 — green.
- i_b in 4 — blue.
- o_x out 10 — recovered active column.
- o_y out 9 — recovered active row.
- o_de out 1 — current sample is an active pixel.
- o_rgb out 12 — sampled colour {b,g,r}; r occupies [3:0].
- o_locked out 1 — timing locked.
- o_frame_start out 1 — one-CLK pulse.
- o_color_a..o_color_d out 12 each — captured quadrant colours.
- o_colors_valid out 1 — one-CLK pulse.

Function
REQ-003 Sampling: i_hs, i_vs and the RGB inputs are registered on strobe cycles only; edge detection compares the current sample with the previous strobe's sample.
REQ-004 hcnt (10 bit) clears to 0 on the strobe where an HS falling edge is detected. Otherwise it increments on each strobe and saturates at 1023.
REQ-005 vcnt (10 bit) clears to 0 on a VS falling edge. Otherwise it increments on each HS falling edge and saturates at 1023.
REQ-006 o_de is 1 iff o_locked=1, H_ACT_OFS <= hcnt < H_ACT_OFS+H_ACT, and V_ACT_OFS <= vcnt < V_ACT_OFS+V_ACT.
REQ-007 When o_de=1: o_x = hcnt-H_ACT_OFS and o_y = vcnt-V_ACT_OFS. When o_de=0, o_x and o_y hold their last values.
REQ-008 o_rgb, o_de, o_x and o_y are registered together, one CLK after the strobe sample, and are updated only on strobes.
REQ-009 The lock FSM has states SEARCH, CHECK and LOCKED; o_locked=1 only in LOCKED.
REQ-010 FSM transitions:
- SEARCH -> CHECK on the first VS falling edge.
- CHECK -> LOCKED on the next VS falling edge, if every line since entering CHECK measured exactly H_TOTAL and the frame measured exactly V_TOTAL lines.
- CHECK -> SEARCH on the first mismatch.
REQ-011 In LOCKED, an HS falling edge with hcnt+1 != H_TOTAL, or a VS falling edge with vcnt+1 != V_TOTAL, forces SEARCH on the next CLK. o_de drops with it.
REQ-012 Missing-edge detection: hcnt reaching 1023 or vcnt reaching 1023 is a mismatch in CHECK and LOCKED.
REQ-013 Simultaneous HS and VS falling edges on one strobe: the line-length check is evaluated first, then the frame check. Both counters clear.
REQ-014 o_frame_start pulses for one CLK on each VS falling edge while in LOCKED.
REQ-015 Quadrant capture, written when o_de=1 at these positions:
- (160,120) -> o_color_a
- (480,120) -> o_color_b
- (160,360) -> o_color_c
- (480,360) -> o_color_d
REQ-016 Each quadrant register updates on the same CLK as o_rgb.
REQ-017 o_colors_valid pulses together with o_frame_start, but only if all four captures occurred in the frame just ended; per-capture flags clear at each VS falling edge.
REQ-018 Loss of lock clears the capture flags; captured colour registers retain their values.
REQ-019 i_pix_stb low: all state holds and no pulses are generated.

Reset
REQ-020 RST=1 asynchronously forces FSM=SEARCH and hcnt=vcnt=0.
REQ-021 RST=1 asynchronously forces all outputs to 0: o_x, o_y, o_de, o_rgb, o_locked, o_frame_start, o_color_a..d, o_colors_valid.
REQ-022 RST=1 clears the capture flags and presets the previous-sample registers to 1 (sync idle high).
REQ-023 Reset asserted mid-frame takes effect immediately; after release, lock requires the full SEARCH -> CHECK -> LOCKED sequence again.

Verification
REQ-024 Standard 640x480 source (800/525, HS low 96, VS low 2 lines), strobe 1 in 4 -> o_locked=1 at the second VS falling edge after reset; exactly 307200 o_de samples per subsequent frame.
REQ-025 Source quadrants A=0x00F, B=0x0F0, C=0xF00, D=0xFFF -> after the first full locked frame, o_color_a..d equal those values and o_colors_valid pulses once per frame.
REQ-026 While locked, one line shortened to 799 strobes -> o_locked falls within 2 CLK of that HS edge; re-lock after two clean frames.
REQ-027 Hold i_vs high for 1100 lines -> vcnt saturates, SEARCH entered, no o_frame_start pulses.
REQ-028 Assert RST at pixel (300,200) of a locked frame -> all outputs 0 on the same cycle; re-lock exactly two VS edges after release.
REQ-029 HS and VS falling edges on the same strobe with correct counts -> lock retained, both counters 0.
